// File: rtl/seg7_pkg.sv
// seg7_pkg -- shared definitions for the 2-digit 7-segment scan display.
//   state_e      : scan slots, in the order they are visited
//                  (S_D0 units, S_B0 blank, S_D1 tens, S_B1 blank).
//   SEG_0..SEG_9 : active-low segment patterns {g,f,e,d,c,b,a}.
//   SEG_DASH     : pattern for non-BCD nibbles (segment g only).
//   SEG_OFF      : all segments dark.
package seg7_pkg;

   typedef enum logic [1:0] {
      S_D0 = 2'd0,
      S_B0 = 2'd1,
      S_D1 = 2'd2,
      S_B1 = 2'd3
   } state_e;

   localparam logic [6:0] SEG_0    = 7'b1000000;
   localparam logic [6:0] SEG_1    = 7'b1111001;
   localparam logic [6:0] SEG_2    = 7'b0100100;
   localparam logic [6:0] SEG_3    = 7'b0110000;
   localparam logic [6:0] SEG_4    = 7'b0011001;
   localparam logic [6:0] SEG_5    = 7'b0010010;
   localparam logic [6:0] SEG_6    = 7'b0000010;
   localparam logic [6:0] SEG_7    = 7'b1111000;
   localparam logic [6:0] SEG_8    = 7'b0000000;
   localparam logic [6:0] SEG_9    = 7'b0010000;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7 -- combinational BCD digit to active-low 7-segment pattern.
//   bcd_i [3:0] : digit value; 10..15 are not BCD and show a dash.
//   seg_o [6:0] : active-low segments {g,f,e,d,c,b,a}.
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_DASH;
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd2_seg7_scan.sv
// bcd2_seg7_scan -- time-multiplexed 2-digit 7-segment driver for a packed
// BCD count. Each frame is four slots of DIV clocks: units, blank, tens,
// blank. The count is captured once per frame (entering the units slot) so
// both digits of a frame always come from the same value.
//   CLK        : clock, rising edge
//   RST        : asynchronous active-high reset
//   CNT  [7:0] : packed BCD, [7:4] tens, [3:0] units
//   SEG  [6:0] : registered segments {g,f,e,d,c,b,a}, polarity SEG_ACT
//   AN   [1:0] : registered digit enables, AN[0] units, AN[1] tens
//   ERR        : registered, high while the captured value has a nibble > 9
// Parameters: DIV (clocks per slot, >= 2), SEG_ACT (0 active-low, 1 active-high).
// Build option: define LEADING_ZERO_BLANK_EN to leave the tens slot dark when
// the captured tens digit is 0; timing and ERR are unaffected.
module bcd2_seg7_scan
   import seg7_pkg::*;
#(
   parameter int DIV     = 50000,
   parameter bit SEG_ACT = 1'b0
)(
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] CNT,
   output logic [6:0] SEG,
   output logic [1:0] AN,
   output logic       ERR
);

   localparam int              PW      = $clog2(DIV);
   localparam logic [PW-1:0]   PRE_MAX = PW'(DIV - 1);
   localparam logic [6:0]      SEG_IDLE = SEG_ACT ? 7'b0000000 : 7'b1111111;
   localparam logic [1:0]      AN_IDLE  = SEG_ACT ? 2'b00 : 2'b11;

   logic [PW-1:0] pre_q, pre_d;
   state_e        state_q, state_d;
   logic [7:0]    shadow_q, shadow_d;
   logic          err_q, err_d;
   logic [6:0]    seg_q, seg_d;
   logic [1:0]    an_q, an_d;

   logic          tick;
   logic [3:0]    digit;
   logic [6:0]    digit_seg;
   logic [6:0]    seg_n;
   logic [1:0]    an_n;

   assign tick = (pre_q == PRE_MAX);

   // Next prescaler, slot and captured count.
   always_comb begin
      pre_d    = tick ? '0 : pre_q + 1'b1;
      state_d  = state_q;
      shadow_d = shadow_q;
      err_d    = err_q;
      if (tick) begin
         case (state_q)
            S_D0:    state_d = S_B0;
            S_B0:    state_d = S_D1;
            S_D1:    state_d = S_B1;
            S_B1:    state_d = S_D0;
            default: state_d = S_B1;
         endcase
         if (state_q == S_B1) begin
            shadow_d = CNT;
            err_d    = (CNT[7:4] > 4'd9) | (CNT[3:0] > 4'd9);
         end
      end
   end

   // Outputs are derived from the next slot and next shadow so the display
   // switches on the same edge as the slot, already showing the new capture.
   assign digit = (state_d == S_D1) ? shadow_d[7:4] : shadow_d[3:0];

   bcd_to_seg7 u_dec (
      .bcd_i (digit),
      .seg_o (digit_seg)
   );

   always_comb begin
      seg_n = SEG_OFF;
      an_n  = 2'b11;
      case (state_d)
         S_D0: begin
            seg_n = digit_seg;
            an_n  = 2'b10;
         end
         S_D1: begin
`ifdef LEADING_ZERO_BLANK_EN
            if (shadow_d[7:4] != 4'd0) begin
               seg_n = digit_seg;
               an_n  = 2'b01;
            end
`else
            seg_n = digit_seg;
            an_n  = 2'b01;
`endif
         end
         default: begin
            seg_n = SEG_OFF;
            an_n  = 2'b11;
         end
      endcase
      seg_d = SEG_ACT ? ~seg_n : seg_n;
      an_d  = SEG_ACT ? ~an_n  : an_n;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pre_q    <= '0;
         state_q  <= S_B1;
         shadow_q <= 8'h00;
         err_q    <= 1'b0;
         seg_q    <= SEG_IDLE;
         an_q     <= AN_IDLE;
      end else begin
         pre_q    <= pre_d;
         state_q  <= state_d;
         shadow_q <= shadow_d;
         err_q    <= err_d;
         seg_q    <= seg_d;
         an_q     <= an_d;
      end
   end

   assign SEG = seg_q;
   assign AN  = an_q;
   assign ERR = err_q;

endmodule

// File: tb/tb_bcd2_seg7_scan.sv
// tb_bcd2_seg7_scan -- bench for bcd2_seg7_scan.
// Instance A: DIV=4, SEG_ACT=0 (directed scenarios plus random count changes).
// Instance B: DIV=2, SEG_ACT=1 (BCD sweep 00..23).
// The reference model counts clock edges since reset release and derives the
// slot arithmetically; the count is captured every 4*DIV edges, DIV edges
// after release.
module tb_bcd2_seg7_scan;

   localparam int DIV_A = 4;
   localparam int DIV_B = 2;

   logic       clk = 1'b0;
   logic       rst_a, rst_b;
   logic [7:0] cnt_a, cnt_b;
   logic [6:0] seg_a, seg_b;
   logic [1:0] an_a, an_b;
   logic       err_a, err_b;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;
   bit b_done   = 1'b0;

   // active-low reference patterns, indexed by digit value
   logic [6:0] pat [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
      7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
   };

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   bcd2_seg7_scan #(.DIV(DIV_A), .SEG_ACT(1'b0)) dut_a (
      .CLK (clk), .RST (rst_a), .CNT (cnt_a),
      .SEG (seg_a), .AN (an_a), .ERR (err_a)
   );

   bcd2_seg7_scan #(.DIV(DIV_B), .SEG_ACT(1'b1)) dut_b (
      .CLK (clk), .RST (rst_b), .CNT (cnt_b),
      .SEG (seg_b), .AN (an_b), .ERR (err_b)
   );

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int         ka = 0, kb = 0;
   logic [7:0] sha = 8'h00, shb = 8'h00;
   logic       erra = 1'b0, errb = 1'b0;

   function automatic bit non_bcd(input logic [7:0] v);
      return (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
   endfunction

   // slot 0 units, 1 blank, 2 tens, 3 blank; reset sits in slot 3
   function automatic int slot_of(input int k, input int div);
      return ((k / div) + 3) % 4;
   endfunction

   task automatic expect_out(input int k, input int div, input logic [7:0] sh, input bit act,
                             output logic [6:0] seg, output logic [1:0] an);
      logic [6:0] s;
      logic [1:0] a;
      int         slot;
      s    = 7'b1111111;
      a    = 2'b11;
      slot = slot_of(k, div);
      if (slot == 0) begin
         s = pat[sh[3:0]];
         a = 2'b10;
      end else if (slot == 2) begin
`ifdef LEADING_ZERO_BLANK_EN
         if (sh[7:4] != 4'd0) begin
            s = pat[sh[7:4]];
            a = 2'b01;
         end
`else
         s = pat[sh[7:4]];
         a = 2'b01;
`endif
      end
      seg = act ? ~s : s;
      an  = act ? ~a : a;
   endtask

   always @(posedge clk or posedge rst_a) begin
      if (rst_a) begin
         ka = 0; sha = 8'h00; erra = 1'b0;
      end else begin
         ka++;
         if (ka % (4 * DIV_A) == DIV_A) begin
            sha  = cnt_a;
            erra = non_bcd(cnt_a);
         end
      end
   end

   always @(posedge clk or posedge rst_b) begin
      if (rst_b) begin
         kb = 0; shb = 8'h00; errb = 1'b0;
      end else begin
         kb++;
         if (kb % (4 * DIV_B) == DIV_B) begin
            shb  = cnt_b;
            errb = non_bcd(cnt_b);
         end
      end
   end

   // ---------------- scoreboard (every falling edge) ----------------
   always @(negedge clk) begin
      logic [6:0] es;
      logic [1:0] ea;
      if (chk_en) begin
         expect_out(ka, DIV_A, sha, 1'b0, es, ea);
         check_eq("seg_a", 32'(seg_a), 32'(es));
         check_eq("an_a",  32'(an_a),  32'(ea));
         check_eq("err_a", 32'(err_a), 32'(erra));
         check_eq("an_a_onehot0", 32'($onehot0(~an_a)), 32'd1);
         expect_out(kb, DIV_B, shb, 1'b1, es, ea);
         check_eq("seg_b", 32'(seg_b), 32'(es));
         check_eq("an_b",  32'(an_b),  32'(ea));
         check_eq("err_b", 32'(err_b), 32'(errb));
         assert ($onehot0(an_b)) else $error("an_b not onehot0: %b", an_b);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   // wait until instance A enters the given slot; bounded
   task automatic wait_slot_a(input int slot, input string tag);
      int  budget;
      bit  left, hit;
      budget = 20 * DIV_A;
      left   = (slot_of(ka, DIV_A) != slot);
      hit    = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         @(negedge clk);
         if (slot_of(ka, DIV_A) != slot) left = 1'b1;
         else if (left) hit = 1'b1;
      end
      #1;
      if (!hit) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   // ---------------- instance B stimulus: BCD sweep ----------------
   initial begin
      cnt_b = 8'h00;
      rst_b = 1'b1;
      step(3);
      rst_b = 1'b0;
      for (int v = 0; v <= 23; v++) begin
         cnt_b = {4'(v / 10), 4'(v % 10)};
         step(4 * DIV_B + $urandom_range(0, 3));
      end
      step(8 * DIV_B);
      b_done = 1'b1;
   end

   // ---------------- instance A stimulus ----------------
   initial begin
      cnt_a = 8'h23;
      rst_a = 1'b1;
      @(posedge clk);
      #1 chk_en = 1'b1;
      step(2);
      rst_a = 1'b0;

      // first DIV cycles blank, then units 3, blank, tens 2
      step(DIV_A - 1);
      check_eq("t1_blank_an", 32'(an_a), 32'(2'b11));
      step(1);
      check_eq("t1_units_an",  32'(an_a),  32'(2'b10));
      check_eq("t1_units_seg", 32'(seg_a), 32'(7'b0110000));
      step(2 * DIV_A);
      check_eq("t1_tens_an",  32'(an_a),  32'(2'b01));
      check_eq("t1_tens_seg", 32'(seg_a), 32'(7'b0100100));
      step(8 * DIV_A);

      // count changes mid-frame: frame must not tear
      cnt_a = 8'h12;
      wait_slot_a(0, "t2_d0");
      step(1);
      cnt_a = 8'h19;
      step(8 * DIV_A);

      // non-BCD units then recovery
      cnt_a = 8'h0A;
      step(8 * DIV_A);
      cnt_a = 8'h07;
      step(8 * DIV_A);

      // leading zero
      cnt_a = 8'h05;
      step(8 * DIV_A);

      // random count changes at random points in the frame
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) == 0) cnt_a = 8'($urandom_range(0, 255));
         step(1);
      end

      // asynchronous reset two cycles into the tens slot
      cnt_a = 8'h23;
      step(8 * DIV_A);
      wait_slot_a(2, "t5_d1");
      step(1);
      rst_a = 1'b1;
      #1;
      check_eq("t5_rst_an",  32'(an_a),  32'(2'b11));
      check_eq("t5_rst_seg", 32'(seg_a), 32'(7'b1111111));
      check_eq("t5_rst_err", 32'(err_a), 32'd0);
      step(2);
      rst_a = 1'b0;
      repeat (DIV_A - 1) @(posedge clk);
      #1 check_eq("t5_pre_d0_an", 32'(an_a), 32'(2'b11));
      @(posedge clk);
      #1 check_eq("t5_d0_an", 32'(an_a), 32'(2'b10));
      step(8 * DIV_A);

      for (int i = 0; i < 1000 && !b_done; i++) @(negedge clk);
      if (!b_done) check_eq("b_sweep_timeout", 32'd0, 32'd1);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
